// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with 2-entry queue and branch redirect
//
// Issues one word-address read at a time to instruction memory, buffers the
// returned words in a 2-entry in-order queue and feeds a registered decode
// register. A taken branch redirects the PC, flushes the queue and the decode
// register, and toggles an epoch bit so that the response to a request issued
// before the branch is discarded when it returns.
//
// Optional build: define FETCH_STAGE_BYPASS_EN to let an accepted response go
// straight into the decode register when the queue is empty (1-cycle
// imem_valid -> validD latency instead of 2).
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-low reset
//   stallD       in   1  decode holds instD/pcD this cycle
//   branch_taken in   1  decode resolved a taken branch this cycle
//   PC_branch    in  12  redirect target, valid with branch_taken
//   imem_req     out  1  fetch request valid
//   imem_addr    out 12  word address of the request
//   imem_gnt     in   1  memory accepts the request this cycle
//   imem_valid   in   1  read data returned this cycle
//   imem_rdata   in  16  instruction word
//   instD        out 16  registered instruction to decode
//   pcD          out 12  address of instD
//   validD       out  1  instD/pcD hold a live instruction

module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        branch_taken,
  input  logic [11:0] PC_branch,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instD,
  output logic [11:0] pcD,
  output logic        validD
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetchState_e;

  fetchState_e state;
  logic [11:0] pc;
  logic        epoch;
  logic        reqEpoch;
  logic [11:0] reqPc;

  // Queue entry 0 is always the head; entry 1 is only meaningful at count 2.
  logic [15:0] qInst0, qInst1;
  logic [11:0] qPc0, qPc1;
  logic [1:0]  qCount;

  logic handshake;
  logic acceptResp;
  logic bypassResp;
  logic pushQ;
  logic popQ;

  assign imem_addr = pc;

  // Only issue from IDLE (at most one outstanding), never into a full queue,
  // and never in the redirect cycle. Gating with reset keeps the request low
  // while reset is held even though the state already reads IDLE.
  assign imem_req  = reset & (state == IDLE) & (qCount != 2'd2) & ~branch_taken;
  assign handshake = imem_req & imem_gnt;

  // A response counts only if a request is outstanding, it was issued in the
  // current epoch, and no redirect is happening this very cycle.
  assign acceptResp = (state == WAIT) & imem_valid & ~branch_taken & (reqEpoch == epoch);

  assign popQ = ~branch_taken & ~stallD & (qCount != 2'd0);

`ifdef FETCH_STAGE_BYPASS_EN
  assign bypassResp = acceptResp & (qCount == 2'd0) & ~stallD;
`else
  assign bypassResp = 1'b0;
`endif

  assign pushQ = acceptResp & ~bypassResp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= 12'h000;
      epoch    <= 1'b0;
      reqEpoch <= 1'b0;
      reqPc    <= 12'h000;
      qInst0   <= 16'h0000;
      qInst1   <= 16'h0000;
      qPc0     <= 12'h000;
      qPc1     <= 12'h000;
      qCount   <= 2'd0;
      instD    <= 16'h0000;
      pcD      <= 12'h000;
      validD   <= 1'b0;
    end else begin
      // Latency tracker: epoch-blind, so a stale response still closes WAIT.
      case (state)
        IDLE: if (handshake) state <= WAIT;
        WAIT: if (imem_valid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (handshake) begin
        reqEpoch <= epoch;
        reqPc    <= pc;
      end

      if (branch_taken) begin
        pc    <= PC_branch;
        epoch <= ~epoch;
      end else if (handshake) begin
        pc <= pc + 12'd1;
      end

      if (branch_taken) begin
        qCount <= 2'd0;
      end else begin
        case ({pushQ, popQ})
          2'b10: begin
            if (qCount == 2'd0) begin
              qInst0 <= imem_rdata;
              qPc0   <= reqPc;
            end else begin
              qInst1 <= imem_rdata;
              qPc1   <= reqPc;
            end
            qCount <= qCount + 2'd1;
          end
          2'b01: begin
            qInst0 <= qInst1;
            qPc0   <= qPc1;
            qCount <= qCount - 2'd1;
          end
          2'b11: begin
            // Simultaneous read and write: occupancy is unchanged.
            if (qCount == 2'd1) begin
              qInst0 <= imem_rdata;
              qPc0   <= reqPc;
            end else begin
              qInst0 <= qInst1;
              qPc0   <= qPc1;
              qInst1 <= imem_rdata;
              qPc1   <= reqPc;
            end
          end
          default: ;
        endcase
      end

      if (branch_taken) begin
        validD <= 1'b0;
      end else if (!stallD) begin
        if (qCount != 2'd0) begin
          instD  <= qInst0;
          pcD    <= qPc0;
          validD <= 1'b1;
        end else if (bypassResp) begin
          instD  <= imem_rdata;
          pcD    <= reqPc;
          validD <= 1'b1;
        end else begin
          validD <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD;
  logic        branch_taken;
  logic [11:0] PC_branch;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_gnt;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] instD;
  logic [11:0] pcD;
  logic        validD;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stallD       (stallD),
    .branch_taken (branch_taken),
    .PC_branch    (PC_branch),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instD        (instD),
    .pcD          (pcD),
    .validD       (validD)
  );

  typedef struct packed {
    logic [15:0] inst;
    logic [11:0] pc;
  } expEntry_t;

  expEntry_t sbQ[$];
  int checks = 0;
  int failures = 0;

  // Memory model state
  int          grantTarget = 0;
  int          grantsDone = 0;
  int          memLat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [11:0] pAddr = 12'h000;

  function automatic logic [15:0] memWord(input logic [11:0] a);
    return {4'h1, a} + 16'h0234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  task automatic expectInst(input logic [15:0] inst, input logic [11:0] pc);
    expEntry_t e;
    e.inst = inst;
    e.pc   = pc;
    sbQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_instD"}, instD, 0);
    check({tag, "_pcD"}, pcD, 0);
    check({tag, "_validD"}, validD, 0);
  endtask

  // Memory: grants while under budget, returns data memLat cycles after handshake.
  initial begin
    imem_gnt   = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_valid = 1'b1;
          imem_rdata = memWord(pAddr);
          pend = 1'b0;
        end
      end
      @(negedge clk);
      imem_gnt = reset && (grantsDone < grantTarget);
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        pAddr = imem_addr;
        cnt   = memLat;
        grantsDone++;
      end
    end
  end

  // Monitor: an instruction in decode is consumed whenever stallD is low.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge clk);
      if (reset && validD && !stallD) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL decode_unexpected actual inst=0x%0h pc=0x%0h required=none", instD, pcD);
        end else begin
          e = sbQ.pop_front();
          check("decode_inst", instD, e.inst);
          check("decode_pc", pcD, e.pc);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    stallD       = 1'b0;
    branch_taken = 1'b0;
    PC_branch    = 12'h000;

    // Reset state
    repeat (3) step();
    #1;
    checkResetOutputs("reset");

    // First fetch after release
    expectInst(16'h1234, 12'h000);
    expectInst(16'h1235, 12'h001);
    grantTarget = 2;
    step();
    reset = 1'b1;
    #1;
    check("s1_req_after_release", imem_req, 1);
    check("s1_addr0", imem_addr, 12'h000);
    step(); #1;
    check("s1_req_outstanding", imem_req, 0);
    step(); #1;
    check("s1_req_next", imem_req, 1);
    check("s1_addr1", imem_addr, 12'h001);
`ifdef FETCH_STAGE_BYPASS_EN
    check("s1_validD", validD, 1);
    check("s1_instD", instD, 16'h1234);
    check("s1_pcD", pcD, 12'h000);
    step(); #1;
`else
    step(); #1;
    check("s1_validD", validD, 1);
    check("s1_instD", instD, 16'h1234);
    check("s1_pcD", pcD, 12'h000);
`endif
    repeat (4) step();

    // PC wrap 0xFFF -> 0x000
    step();
    branch_taken = 1'b1;
    PC_branch    = 12'hFFF;
    expectInst(16'h2233, 12'hFFF);
    expectInst(16'h1234, 12'h000);
    grantTarget = 4;
    #1;
    check("s2_no_req_branch_cycle", imem_req, 0);
    step();
    branch_taken = 1'b0;
    #1;
    check("s2_req_target", imem_req, 1);
    check("s2_addr_fff", imem_addr, 12'hFFF);
    step();
    step(); #1;
    check("s2_addr_wrap", imem_addr, 12'h000);
    step();
    repeat (4) step();

    // Stall while the queue fills to 2
    expectInst(16'h1235, 12'h001);
    expectInst(16'h1236, 12'h002);
    expectInst(16'h1237, 12'h003);
    grantTarget = 7;
    step();
    step();
    step();
    stallD = 1'b1;
    #1;
    check("s3_validD_held", validD, 1);
    check("s3_instD_held", instD, 16'h1235);
    step(); #1;
    check("s3_instD_stable1", instD, 16'h1235);
    step(); #1;
    check("s3_instD_stable2", instD, 16'h1235);
    check("s3_req_outstanding", imem_req, 0);
    step();
    stallD = 1'b0;
    #1;
    check("s3_req_queue_full", imem_req, 0);
    check("s3_instD_stable3", instD, 16'h1235);
    step(); #1;
    check("s3_req_resume", imem_req, 1);
    check("s3_addr_resume", imem_addr, 12'h004);
    step();
    repeat (2) step();

    // Branch with a response outstanding
    memLat = 3;
    grantTarget = 8;
    expectInst(16'h12B4, 12'h080);
    step();
    step();
    branch_taken = 1'b1;
    PC_branch    = 12'h080;
    #1;
    check("s4_no_req_branch_cycle", imem_req, 0);
    step();
    branch_taken = 1'b0;
    memLat = 1;
    grantTarget = 9;
    #1;
    check("s4_validD_after_branch", validD, 0);
    check("s4_req_while_stale", imem_req, 0);
    step(); #1;
    check("s4_req_target", imem_req, 1);
    check("s4_addr_080", imem_addr, 12'h080);
    check("s4_stale_dropped0", validD, 0);
    step(); #1;
    check("s4_stale_dropped1", validD, 0);
    repeat (4) step();

    // Branch and stall together with a full queue
    grantTarget = 12;
    step();
    step();
    step();
    stallD = 1'b1;
    #1;
    check("s5_validD_held", validD, 1);
    check("s5_instD_held", instD, 16'h12B5);
    step();
    step();
    step();
    branch_taken = 1'b1;
    PC_branch    = 12'h200;
    #1;
    check("s5_no_req_branch_cycle", imem_req, 0);
    step();
    branch_taken = 1'b0;
    stallD = 1'b0;
    #1;
    check("s5_validD_flushed", validD, 0);
    check("s5_req_target", imem_req, 1);
    check("s5_addr_200", imem_addr, 12'h200);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("s5_queue_flushed", validD, 0);
    end

    // Reset while waiting, late response afterwards
    memLat = 4;
    grantTarget = 13;
    step(); #1;
    check("s6_wait_req", imem_req, 0);
    reset = 1'b0;
    #1;
    checkResetOutputs("s6_in_reset");
    step(); #1;
    checkResetOutputs("s6_in_reset2");
    step();
    reset = 1'b1;
    #1;
    check("s6_req_after_release", imem_req, 1);
    check("s6_addr_after_release", imem_addr, 12'h000);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("s6_late_valid_ignored", validD, 0);
      check("s6_instD_reset", instD, 0);
      check("s6_pcD_reset", pcD, 0);
    end

    check("scoreboard_drained", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
